// File: rtl/uart_stream_ctrl.sv
// uart_stream_ctrl
// ----------------
// Streams a frame of bytes from the synchronous buffer RAM to the UART
// transmitter. An accepted start captures base_addr, length and loop. The
// controller then walks the RAM from the base address and wraps at the top of
// RAM. For every byte it fetches the data, loads tx_byte and issues a single
// transmit strobe. It then waits for the UART's is_transmitting handshake to
// rise and fall before it moves to the next byte.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start          one-cycle command, only honoured while idle
//   base_addr      first RAM address of the frame
//   length         byte count 0..2**ADDR_WIDTH
//   loop           repeat the frame until abort
//   abort          level; stops streaming at the next byte boundary
//   ram_addr       registered RAM read address
//   ram_rdata      RAM data, valid one cycle after ram_addr
//   tx_transmit    one-cycle transmit strobe to the UART
//   tx_byte        byte presented to the UART
//   tx_busy        UART is_transmitting
//   busy           controller is not idle
//   done           one-cycle end-of-frame / end-of-abort pulse
//   aborted        frame ended by abort; held until the next start
//   error          sticky acknowledge-timeout flag
//   byte_count     bytes fully sent in the current pass
module uart_stream_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  loop,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  tx_transmit,
    output logic [DATA_WIDTH-1:0] tx_byte,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_IDLE,
        ST_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     length_q, length_d;
    logic                    loop_q, loop_d;
    logic [DATA_WIDTH-1:0]   tx_byte_q, tx_byte_d;
    logic                    tx_transmit_q, tx_transmit_d;
    logic [ADDR_WIDTH:0]     byte_count_q, byte_count_d;
    logic                    aborted_q, aborted_d;
    logic                    error_q, error_d;
    logic                    abort_pend_q, abort_pend_d;
    logic [TW-1:0]           timeout_q, timeout_d;
    logic [ADDR_WIDTH:0]     count_next;
    logic                    stop_req;

    assign count_next = byte_count_q + (ADDR_WIDTH+1)'(1);
    // A pulse of abort may arrive while a byte is in flight, so the latched
    // copy is honoured alongside the live level.
    assign stop_req   = abort | abort_pend_q;

    always_comb begin
        state_d       = state_q;
        ram_addr_d    = ram_addr_q;
        base_d        = base_q;
        length_d      = length_q;
        loop_d        = loop_q;
        tx_byte_d     = tx_byte_q;
        tx_transmit_d = 1'b0;
        byte_count_d  = byte_count_q;
        aborted_d     = aborted_q;
        error_d       = error_q;
        abort_pend_d  = abort_pend_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d      = 1'b0;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    byte_count_d = '0;
                    if (length != '0) begin
                        base_d     = base_addr;
                        length_d   = length;
                        loop_d     = loop;
                        ram_addr_d = base_addr;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_FETCH: begin
                if (stop_req) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (stop_req) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    tx_byte_d = ram_rdata;
                    state_d   = ST_SEND;
                end
            end

            // The strobe is registered, so it is high during the first
            // WAIT_ACK cycle and drops on its own one cycle later.
            ST_SEND: begin
                tx_transmit_d = 1'b1;
                timeout_d     = '0;
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                state_d = ST_WAIT_ACK;
            end

            // A missing acknowledge flags the error. The byte is then treated
            // as sent so that the frame still completes.
            ST_WAIT_ACK: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (tx_busy) begin
                    state_d = ST_WAIT_IDLE;
                end else if (timeout_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end else begin
                    timeout_d = timeout_q + TW'(1);
                end
            end

            ST_WAIT_IDLE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (!tx_busy) begin
                    byte_count_d = count_next;
                    ram_addr_d   = ram_addr_q + ADDR_WIDTH'(1);
                    if (stop_req) begin
                        aborted_d = 1'b1;
                        state_d   = ST_FINISH;
                    end else if (count_next == length_q) begin
                        if (loop_q) begin
                            byte_count_d = '0;
                            ram_addr_d   = base_q;
                            state_d      = ST_FETCH;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FINISH: begin
                abort_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ram_addr_q    <= '0;
            base_q        <= '0;
            length_q      <= '0;
            loop_q        <= 1'b0;
            tx_byte_q     <= '0;
            tx_transmit_q <= 1'b0;
            byte_count_q  <= '0;
            aborted_q     <= 1'b0;
            error_q       <= 1'b0;
            abort_pend_q  <= 1'b0;
            timeout_q     <= '0;
        end else begin
            state_q       <= state_d;
            ram_addr_q    <= ram_addr_d;
            base_q        <= base_d;
            length_q      <= length_d;
            loop_q        <= loop_d;
            tx_byte_q     <= tx_byte_d;
            tx_transmit_q <= tx_transmit_d;
            byte_count_q  <= byte_count_d;
            aborted_q     <= aborted_d;
            error_q       <= error_d;
            abort_pend_q  <= abort_pend_d;
            timeout_q     <= timeout_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign tx_transmit = tx_transmit_q;
    assign tx_byte     = tx_byte_q;
    assign byte_count  = byte_count_q;
    assign aborted     = aborted_q;
    assign error       = error_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FINISH);

endmodule

// File: tb/tb_uart_stream_ctrl.sv
module tb_uart_stream_ctrl;

    localparam int UART_CYCLES = 6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  length;
    logic        loop;
    logic        abort;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_rdata;
    logic        tx_transmit;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        error;
    logic [9:0]  byte_count;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
    } tx_exp_t;

    typedef struct {
        logic       ab;
        logic [9:0] cnt;
    } done_exp_t;

    tx_exp_t   tx_q[$];
    done_exp_t done_q[$];

    int checks;
    int errors;
    int cyc;
    int fall_cyc;
    int strobe_count;
    logic prev_busy;
    logic ack_disable;
    int busy_cnt;
    logic [7:0] mem [512];

    uart_stream_ctrl #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (8),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .loop       (loop),
        .abort      (abort),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .tx_transmit(tx_transmit),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .error      (error),
        .byte_count (byte_count)
    );

    // Free-running clock and a cycle counter used for latency measurements
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read buffer RAM model
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    // UART model: a sampled strobe makes it busy for a fixed number of cycles
    // unless acknowledges are suppressed to provoke the timeout
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (tx_transmit && !ack_disable) busy_cnt <= UART_CYCLES;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    // Generic comparison helper shared by the monitors and the main sequence
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Transmit monitor: each strobe pops the next expected byte/address and
    // confirms the strobe never overlaps a busy UART
    always @(negedge clk) begin
        if (rst_n && tx_transmit) begin
            strobe_count++;
            checkOutput("strobe_while_busy", {31'd0, tx_busy}, 32'd0);
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_tx actual=0x%0h expected=none", tx_byte);
            end else begin
                tx_exp_t e;
                e = tx_q.pop_front();
                checkOutput("tx_byte", {24'd0, tx_byte}, {24'd0, e.data});
                checkOutput("tx_addr", {23'd0, ram_addr}, {23'd0, e.addr});
            end
        end
    end

    // Completion monitor: each done pulse pops the expected abort flag and count
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0");
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                checkOutput("done_aborted", {31'd0, aborted}, {31'd0, d.ab});
                checkOutput("done_byte_count", {22'd0, byte_count}, {22'd0, d.cnt});
            end
        end
    end

    // Record the cycle of the most recent falling edge of tx_busy
    always @(negedge clk) begin
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
    end

    // Hard stop in case the sequence wedges somewhere unexpected
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one start command; returns at the negedge after start is sampled
    task automatic applyStimulus(input logic [8:0] b, input logic [9:0] len, input logic lp);
        @(negedge clk);
        base_addr = b;
        length    = len;
        loop      = lp;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic pushTx(input logic [8:0] a, input logic [7:0] d);
        tx_exp_t e;
        e.addr = a;
        e.data = d;
        tx_q.push_back(e);
    endtask

    task automatic pushDone(input logic ab, input logic [9:0] cnt);
        done_exp_t d;
        d.ab  = ab;
        d.cnt = cnt;
        done_q.push_back(d);
    endtask

    task automatic waitDone(input string name, input int budget, output int done_cyc);
        bit seen;
        seen = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int dc;
        int s0;
        int n;
        int es;
        int ee;

        checks = 0;
        errors = 0;
        strobe_count = 0;
        fall_cyc = 0;
        prev_busy = 1'b0;
        ack_disable = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        loop = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[9'h010] = 8'h41;
        mem[9'h011] = 8'h42;
        mem[9'h012] = 8'h43;
        mem[9'h020] = 8'h61;
        mem[9'h021] = 8'h62;
        mem[9'h030] = 8'h71;
        mem[9'h031] = 8'h72;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ram_addr", {23'd0, ram_addr}, 32'd0);
        checkOutput("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        checkOutput("rst_tx_transmit", {31'd0, tx_transmit}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_flags", {30'd0, aborted, error}, 32'd0);
        checkOutput("rst_byte_count", {22'd0, byte_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Three-byte frame from 0x10
        $display("[TB] basic frame");
        pushTx(9'h010, 8'h41);
        pushTx(9'h011, 8'h42);
        pushTx(9'h012, 8'h43);
        pushDone(1'b0, 10'd3);
        s0 = strobe_count;
        applyStimulus(9'h010, 10'd3, 1'b0);
        n = 0;
        for (int i = 0; i < 20 && !tx_transmit; i++) begin
            @(negedge clk);
            n++;
        end
        checkOutput("strobe_latency", n, 3);
        waitDone("basic", 200, dc);
        checkOutput("done_after_busy_fall", dc - fall_cyc, 1);
        @(negedge clk);
        checkOutput("basic_strobes", strobe_count - s0, 3);
        checkOutput("basic_byte_count", {22'd0, byte_count}, 32'd3);
        checkOutput("basic_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("basic_error", {31'd0, error}, 32'd0);

        // Address wrap at the top of RAM
        $display("[TB] wrap frame");
        pushTx(9'h1FE, 8'h5B);
        pushTx(9'h1FF, 8'h5A);
        pushTx(9'h000, 8'hA5);
        pushTx(9'h001, 8'hA4);
        pushDone(1'b0, 10'd4);
        applyStimulus(9'h1FE, 10'd4, 1'b0);
        waitDone("wrap", 300, dc);
        @(negedge clk);
        checkOutput("wrap_end_addr", {23'd0, ram_addr}, 32'h002);

        // Zero-length start: immediate done, nothing sent, address untouched
        $display("[TB] zero length");
        pushDone(1'b0, 10'd0);
        s0 = strobe_count;
        applyStimulus(9'h0AB, 10'd0, 1'b0);
        checkOutput("len0_done_now", {31'd0, done}, 32'd1);
        waitDone("len0", 5, dc);
        @(negedge clk);
        checkOutput("len0_strobes", strobe_count - s0, 0);
        checkOutput("len0_ram_addr", {23'd0, ram_addr}, 32'h002);
        checkOutput("len0_busy", {31'd0, busy}, 32'd0);

        // Looping frame aborted during the fifth byte's acknowledge wait
        $display("[TB] loop with abort");
        pushTx(9'h020, 8'h61);
        pushTx(9'h021, 8'h62);
        pushTx(9'h020, 8'h61);
        pushTx(9'h021, 8'h62);
        pushTx(9'h020, 8'h61);
        pushDone(1'b1, 10'd1);
        s0 = strobe_count;
        applyStimulus(9'h020, 10'd2, 1'b1);
        n = 0;
        for (int i = 0; i < 400 && n < 5; i++) begin
            if (tx_transmit) n++;
            if (n < 5) @(negedge clk);
        end
        checkOutput("loop_fifth_strobe_seen", n, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitDone("loop_abort", 100, dc);
        @(negedge clk);
        checkOutput("loop_strobes", strobe_count - s0, 5);
        checkOutput("loop_aborted_held", {31'd0, aborted}, 32'd1);

        // Acknowledge timeout: tx_busy never rises
        $display("[TB] ack timeout");
        ack_disable = 1'b1;
        pushTx(9'h030, 8'h71);
        pushTx(9'h031, 8'h72);
        pushDone(1'b0, 10'd2);
        s0 = strobe_count;
        applyStimulus(9'h030, 10'd2, 1'b0);
        checkOutput("timeout_aborted_cleared", {31'd0, aborted}, 32'd0);
        es = -1;
        for (int i = 0; i < 20 && es < 0; i++) begin
            if (tx_transmit) es = cyc;
            else @(negedge clk);
        end
        ee = -1;
        for (int i = 0; i < 40 && ee < 0; i++) begin
            if (error) ee = cyc;
            else @(negedge clk);
        end
        checkOutput("error_rise_delay", ee - es, 16);
        waitDone("timeout", 200, dc);
        @(negedge clk);
        checkOutput("timeout_strobes", strobe_count - s0, 2);
        checkOutput("error_sticky", {31'd0, error}, 32'd1);
        ack_disable = 1'b0;

        // A new start clears the sticky error
        pushTx(9'h010, 8'h41);
        pushDone(1'b0, 10'd1);
        applyStimulus(9'h010, 10'd1, 1'b0);
        checkOutput("error_cleared_on_start", {31'd0, error}, 32'd0);
        waitDone("clear", 100, dc);

        // Asynchronous reset while waiting for the UART to go idle
        $display("[TB] reset mid frame");
        pushTx(9'h010, 8'h41);
        pushTx(9'h011, 8'h42);
        pushTx(9'h012, 8'h43);
        pushDone(1'b0, 10'd3);
        applyStimulus(9'h010, 10'd3, 1'b0);
        n = 0;
        for (int i = 0; i < 40 && !tx_busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_busy", {30'd0, busy, tx_busy}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_ram_addr", {23'd0, ram_addr}, 32'd0);
        checkOutput("arst_tx_byte", {24'd0, tx_byte}, 32'd0);
        checkOutput("arst_byte_count", {22'd0, byte_count}, 32'd0);
        checkOutput("arst_flags", {29'd0, tx_transmit, done, error}, 32'd0);
        tx_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushTx(9'h1FE, 8'h5B);
        pushTx(9'h1FF, 8'h5A);
        pushDone(1'b0, 10'd2);
        applyStimulus(9'h1FE, 10'd2, 1'b0);
        waitDone("post_reset", 200, dc);
        @(negedge clk);
        checkOutput("post_reset_addr", {23'd0, ram_addr}, 32'h000);

        repeat (3) @(negedge clk);
        checkOutput("tx_queue_empty", tx_q.size(), 0);
        checkOutput("done_queue_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
